bram_sdp: RTL and testbench
===========================

BRAM_SDP -- requirements
Module: bram_sdp

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 128, SHALL set the number of entries.
REQ-003 Parameter ADDR_W, default 7 (clog2(DEPTH)), SHALL set the address width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 we  input  1  SHALL be the write enable; a write occurs when it is high at a rising edge.
REQ-007 wr_addr  input  ADDR_W  SHALL be the write address.
REQ-008 rd_addr  input  ADDR_W  SHALL be the read address, sampled every cycle.
REQ-009 data_in  input  WIDTH  SHALL be the write data.
REQ-010 data_out  output  WIDTH  SHALL be the registered read data.

Function
REQ-011 The block SHALL be a simple dual-port RAM: one write port and one read port, both on clk, independent addresses.
REQ-012 Write: when we=1 at a rising edge, mem[wr_addr] SHALL take data_in; when we=0, memory SHALL be unchanged.
REQ-013 Read: at every rising edge, data_out SHALL take mem[rd_addr]; read latency SHALL be exactly 1 cycle.
REQ-014 There SHALL be no read enable; data_out SHALL update every cycle, and holding rd_addr constant SHALL hold data_out stable unless that entry is written.
REQ-015 Read and write to the same address in the same edge SHALL be read-first: data_out SHALL show the old contents, and the new data SHALL be visible on the following read.
REQ-016 Writes to different addresses in consecutive cycles SHALL each complete in one cycle, with no back-pressure.
REQ-017 Addresses SHALL be full-range; with DEPTH=2^ADDR_W, every address code SHALL be valid.
REQ-018 If DEPTH < 2^ADDR_W, writes to out-of-range addresses SHALL be ignored and out-of-range reads SHALL return 0.
REQ-019 Memory contents SHALL be undefined (X in simulation) until written, and the memory SHALL NOT be initialised from a file.
REQ-020 The array SHALL be coded so synthesis infers block RAM, with no reset on the array.

Reset
REQ-021 Asserting rst SHALL clear data_out to 0 immediately, without waiting for a clock edge.
REQ-022 rst SHALL NOT alter memory contents; data written before reset SHALL be readable after reset.
REQ-023 While rst=1, writes SHALL be blocked and data_out SHALL stay 0.
REQ-024 The first read after rst deasserts SHALL return valid data one cycle after the first rising edge.

Structure
REQ-025 WIDTH, DEPTH and ADDR_W defaults SHALL live in a shared package (bram_pkg) as localparams, and the module parameters SHALL default to them.
REQ-026 The block SHALL be a single module with no sub-modules; the array and the output register SHALL live in bram_sdp.

Verification
REQ-027 Fill test: write entries 0..127, entry i = little-endian pack of bytes 8i..8i+7 (entry 0 = 64'h0706050403020100); read back all 128 -> each matches, 1-cycle latency.
REQ-028 Latency check: write mem[5]=64'hDEADBEEF_CAFEF00D; set rd_addr=5 -> data_out updates at exactly the next rising edge, not before.
REQ-029 Collision: mem[9]=64'h1111; in the same edge write 64'h2222 to addr 9 and read addr 9 -> 64'h1111, and the next cycle -> 64'h2222.
REQ-030 Write disable: we=0 with wr_addr=3 and data_in=64'hFFFF -> mem[3] keeps its prior value on readback.
REQ-031 Async reset mid-read: data_out=nonzero; pulse rst between edges -> data_out=0 at once, with no clock edge needed.
REQ-032 After reset release, readback of previously written entries matches, and a write attempted during rst has no effect.

Source files
------------

// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared defaults for the simple dual-port block RAM (bram_sdp).
//   BRAM_WIDTH  : data word width in bits
//   BRAM_DEPTH  : number of entries
//   BRAM_ADDR_W : address width, sized to cover BRAM_DEPTH
// ---------------------------------------------------------------------------
package bram_pkg;

  localparam int BRAM_WIDTH  = 64;
  localparam int BRAM_DEPTH  = 128;
  localparam int BRAM_ADDR_W = $clog2(BRAM_DEPTH);

endpackage

// File: rtl/bram_sdp.sv
// ---------------------------------------------------------------------------
// bram_sdp
// Simple dual-port RAM: one write port and one registered read port, both on
// clk. Reads are read-first on same-address collisions, with 1-cycle latency.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   async active-high reset; clears data_out only, blocks writes
//   we       in   write enable
//   wr_addr  in   write address  [ADDR_W]
//   rd_addr  in   read address   [ADDR_W], sampled every cycle
//   data_in  in   write data     [WIDTH]
//   data_out out  registered read data [WIDTH]
// ---------------------------------------------------------------------------
module bram_sdp
  import bram_pkg::*;
#(
  parameter int WIDTH  = BRAM_WIDTH,
  parameter int DEPTH  = BRAM_DEPTH,
  parameter int ADDR_W = BRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out
);

  // Array has no reset so synthesis can map it onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_ok;
  logic rd_ok;

  // Range checks are only needed when the address space is larger than the
  // array; otherwise every code is valid and the compare is dropped entirely.
  generate
    if (DEPTH < (1 << ADDR_W)) begin : g_partial
      localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
      assign wr_ok = ({1'b0, wr_addr} < DEPTH_W);
      assign rd_ok = ({1'b0, rd_addr} < DEPTH_W);
    end else begin : g_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end
  endgenerate

  // Write port: rst acts as a plain write block so the array stays reset-free.
  always_ff @(posedge clk) begin
    if (we && !rst && wr_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Read port: non-blocking read of the array gives read-first behaviour when
  // the same address is written on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rd_addr];
    end else begin
      data_out <= '0;
    end
  end

endmodule

// File: tb/tb_bram_sdp.sv
// ---------------------------------------------------------------------------
// tb_bram_sdp
// Directed self-checking bench for bram_sdp at default parameters.
// ---------------------------------------------------------------------------
module tb_bram_sdp;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;

  logic [WIDTH-1:0]  model [DEPTH];

  int checks;
  int failures;

  bram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Fill pattern: entry i holds bytes 8i..8i+7, little-endian, modulo 256.
  function automatic logic [WIDTH-1:0] fillWord(input int i);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      w[8*k +: 8] = 8'(8*i + k);
    end
    return w;
  endfunction

  // Drive one cycle of inputs at a falling edge, then wait for the next
  // falling edge so exactly one rising edge has consumed them.
  task automatic applyStimulus(input logic w_en, input logic [ADDR_W-1:0] wa,
                               input logic [WIDTH-1:0] wd,
                               input logic [ADDR_W-1:0] ra);
    we      = w_en;
    wr_addr = wa;
    data_in = wd;
    rd_addr = ra;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    we       = 1'b0;
    wr_addr  = '0;
    rd_addr  = '0;
    data_in  = '0;

    #1;
    checkOutput("reset_init", data_out, 64'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_held", data_out, 64'h0);
    rst = 1'b0;

    // Fill every entry, then read all back with one-cycle latency.
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = fillWord(i);
      applyStimulus(1'b1, ADDR_W'(i), model[i], '0);
    end
    checkOutput("fill_entry0_const", model[0], 64'h0706050403020100);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, '0, ADDR_W'(i));
      checkOutput($sformatf("fill_rd%0d", i), data_out, model[i]);
    end

    // Latency: data_out must not move until the rising edge after rd_addr.
    applyStimulus(1'b1, 7'd5, 64'hDEADBEEF_CAFEF00D, 7'd4);
    model[5] = 64'hDEADBEEF_CAFEF00D;
    checkOutput("lat_prev", data_out, 64'h27262524_23222120);
    we      = 1'b0;
    rd_addr = 7'd5;
    #2;
    checkOutput("lat_before_edge", data_out, 64'h27262524_23222120);
    @(negedge clk);
    checkOutput("lat_after_edge", data_out, 64'hDEADBEEF_CAFEF00D);

    // Same-address write and read on one edge returns old data first.
    applyStimulus(1'b1, 7'd9, 64'h1111, 7'd0);
    applyStimulus(1'b1, 7'd9, 64'h2222, 7'd9);
    checkOutput("coll_old", data_out, 64'h1111);
    model[9] = 64'h2222;
    applyStimulus(1'b0, '0, '0, 7'd9);
    checkOutput("coll_new", data_out, 64'h2222);

    // we=0 leaves memory untouched; held rd_addr holds data_out.
    applyStimulus(1'b0, 7'd3, 64'hFFFF, 7'd0);
    applyStimulus(1'b0, '0, '0, 7'd3);
    checkOutput("wdis_rd3", data_out, 64'h1f1e1d1c_1b1a1918);
    applyStimulus(1'b0, '0, '0, 7'd3);
    checkOutput("hold_rd3", data_out, 64'h1f1e1d1c_1b1a1918);

    // Back-to-back writes to different addresses each land in one cycle.
    applyStimulus(1'b1, 7'd20, 64'hA0A0, 7'd3);
    applyStimulus(1'b1, 7'd21, 64'hA1A1, 7'd20);
    checkOutput("b2b_rd20", data_out, 64'hA0A0);
    applyStimulus(1'b0, '0, '0, 7'd21);
    checkOutput("b2b_rd21", data_out, 64'hA1A1);
    model[20] = 64'hA0A0;
    model[21] = 64'hA1A1;

    // Async reset between edges: output clears with no clock edge.
    applyStimulus(1'b0, '0, '0, 7'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", data_out, 64'h0);
    we      = 1'b1;
    wr_addr = 7'd3;
    data_in = '1;
    rd_addr = 7'd3;
    @(negedge clk);
    checkOutput("rst_hold_out", data_out, 64'h0);
    rst = 1'b0;

    // After release: earlier contents survive and the blocked write is gone.
    applyStimulus(1'b0, '0, '0, 7'd3);
    checkOutput("post_rst_rd3", data_out, model[3]);
    applyStimulus(1'b0, '0, '0, 7'd9);
    checkOutput("post_rst_rd9", data_out, 64'h2222);
    applyStimulus(1'b0, '0, '0, 7'd5);
    checkOutput("post_rst_rd5", data_out, 64'hDEADBEEF_CAFEF00D);
    applyStimulus(1'b0, '0, '0, 7'd127);
    checkOutput("post_rst_rd127", data_out, 64'hfffefdfc_fbfaf9f8);
    applyStimulus(1'b0, '0, '0, 7'd0);
    checkOutput("post_rst_rd0", data_out, 64'h07060504_03020100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
